// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ula_pkg
//  Description : Shared definitions for the ULA arbiter slice: datapath width,
//                opcode encodings and arbiter FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package ula_pkg;

    localparam int WIDTH = 8;
    localparam int OPW   = 3;

    localparam logic [OPW-1:0] OP_AND   = 3'b000;
    localparam logic [OPW-1:0] OP_OR    = 3'b001;
    localparam logic [OPW-1:0] OP_XOR   = 3'b010;
    localparam logic [OPW-1:0] OP_NOT   = 3'b011;
    localparam logic [OPW-1:0] OP_ADD   = 3'b100;
    localparam logic [OPW-1:0] OP_SUB   = 3'b101;
    localparam logic [OPW-1:0] OP_PASSA = 3'b110;
    localparam logic [OPW-1:0] OP_PASSB = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage : ula_pkg
`default_nettype wire

// File: rtl/ula_core8.sv
`default_nettype none
// ============================================================================
//  Module      : ula_core8
//  Description : Purely combinational 8-bit ALU datapath.
//                Logic ops AND/OR/XOR/NOT, ADD, SUB (A + ~B + 1), pass A/B.
//  Ports       : op_i     opcode
//                a_i,b_i  operands
//                result_o result (modulo 256)
//                carry_o  ADD carry-out / SUB no-borrow, 0 otherwise
//  Revision    : 1.0  initial release
// ============================================================================
module ula_core8
    import ula_pkg::*;
(
    input  logic [OPW-1:0]   op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o
);

    // One shared adder serves both ADD and SUB: SUB inverts B and injects
    // a carry-in, so the carry-out reads directly as "no borrow" (A >= B).
    logic             sub_sel;
    logic [WIDTH-1:0] b_add;
    logic [WIDTH:0]   sum;

    always_comb begin
        sub_sel = (op_i == OP_SUB);
        b_add   = sub_sel ? ~b_i : b_i;
        sum     = {1'b0, a_i} + {1'b0, b_add} + {{WIDTH{1'b0}}, sub_sel};
    end

    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        case (op_i)
            OP_AND:   result_o = a_i & b_i;
            OP_OR:    result_o = a_i | b_i;
            OP_XOR:   result_o = a_i ^ b_i;
            OP_NOT:   result_o = ~a_i;
            OP_ADD,
            OP_SUB: begin
                result_o = sum[WIDTH-1:0];
                carry_o  = sum[WIDTH];
            end
            OP_PASSA: result_o = a_i;
            OP_PASSB: result_o = b_i;
            default:  result_o = '0;
        endcase
    end

endmodule : ula_core8
`default_nettype wire

// File: rtl/ula_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ula_arbiter
//  Description : Two-port round-robin arbiter and sequencer for the shared
//                8-bit ALU. IDLE arbitrates and latches one request, EXEC
//                runs the datapath and registers result/flags, RESP holds the
//                tagged response until the consumer takes it.
//  Ports       : clk, rst_n                  clock, async active-low reset
//                reqN_valid/ready/op/a/b     requester N handshake + payload
//                rsp_valid/ready             response handshake
//                rsp_id/result/carry/zero    tagged response payload
//                busy                        FSM not in IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module ula_arbiter
    import ula_pkg::*;
#(
    parameter int WIDTH = ula_pkg::WIDTH,
    parameter int OPW   = ula_pkg::OPW
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             busy
);

    generate
        if (WIDTH != 8 || OPW != 3) begin : g_param_check
            $error("ula_arbiter supports only WIDTH=8, OPW=3");
        end
    endgenerate

    state_t           state_q,      state_d;
    logic             last_grant_q, last_grant_d;
    logic [OPW-1:0]   op_q,         op_d;
    logic [WIDTH-1:0] a_q,          a_d;
    logic [WIDTH-1:0] b_q,          b_d;
    logic             id_q,         id_d;
    logic [WIDTH-1:0] result_q,     result_d;
    logic             carry_q,      carry_d;
    logic             zero_q,       zero_d;
    logic             rsp_valid_q,  rsp_valid_d;
    logic             busy_q,       busy_d;

    logic             grant0;
    logic             grant1;
    logic [WIDTH-1:0] core_result;
    logic             core_carry;

    ula_core8 u_core (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (core_result),
        .carry_o  (core_carry)
    );

    // Round-robin: a lone requester always wins; on a tie the one that was
    // not granted last time wins.
    always_comb begin
        grant0 = req0_valid && (!req1_valid ||  last_grant_q);
        grant1 = req1_valid && (!req0_valid || !last_grant_q);
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        result_d     = result_q;
        carry_d      = carry_q;
        zero_d       = zero_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                // Grants are mutually exclusive and already include valid,
                // so a grant here is an accepted handshake.
                if (grant0) begin
                    op_d         = req0_op;
                    a_d          = req0_a;
                    b_d          = req0_b;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = ST_EXEC;
                end else if (grant1) begin
                    op_d         = req1_op;
                    a_d          = req1_a;
                    b_d          = req1_b;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = core_result;
                carry_d  = core_carry;
                zero_d   = (core_result == '0);
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered from the next state so they line up
        // exactly with the state they describe.
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            result_q     <= '0;
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            result_q     <= result_d;
            carry_q      <= carry_d;
            zero_q       <= zero_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_carry  = carry_q;
    assign rsp_zero   = zero_q;
    assign busy       = busy_q;

endmodule : ula_arbiter
`default_nettype wire
